stream_demux: RTL

// - Registered, valid/ready-handshaked demux: routes each DATA_W-bit input beat to one of NUM_ELEM outputs.
// - Destination is chosen by a per-beat select captured alongside the data.
// - Sequential successor of the combinational single-bit demux: arbitrary width, full throughput, backpressure, bad-select error.
// - Sits between one producer stream and NUM_ELEM consumer streams.

---
 rtl/demux_pkg.sv | 8 +
 rtl/stream_demux_fifo2.sv | 51 +++++
 rtl/stream_demux.sv | 78 +++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared helpers for the stream demux: select-width derivation.
package demux_pkg;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_demux_fifo2.sv
// Two-entry valid/ready FIFO built from a head register and a tail register.
// The head register doubles as the output, so out_data holds its last value once drained.
module stream_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [1:0]       count_q;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic             push;
    logic             pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) head_q <= in_data;
                    else                 tail_q <= in_data;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) head_q <= tail_q;
                    count_q <= count_q - 2'd1;
                end
                // push and pop together only happen at occupancy 1
                2'b11:   head_q <= in_data;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Registered valid/ready demux: each beat goes to the output named by its select.
// Out-of-range selects are swallowed, flagged on err_o and counted.
module stream_demux
    import demux_pkg::*;
#(
    parameter  int NUM_ELEM = 7,
    parameter  int DATA_W   = 8,
    parameter  int CNT_W    = 8,
    localparam int SEL_W    = sel_w(NUM_ELEM)
) (
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic [SEL_W-1:0]    s_i,
    input  logic [DATA_W-1:0]   data_i,
    input  logic                valid_i,
    output logic                ready_o,
    output logic [DATA_W-1:0]   data_o,
    output logic [NUM_ELEM-1:0] valid_o,
    input  logic [NUM_ELEM-1:0] ready_i,
    output logic                err_o,
    output logic [CNT_W-1:0]    drop_cnt_o
);

    localparam int             WIDTH = SEL_W + DATA_W;
    localparam logic [SEL_W:0] NUM_C = (SEL_W + 1)'(NUM_ELEM);

    logic             sel_ok;
    logic             drop;
    logic             head_valid;
    logic             head_ready;
    logic [WIDTH-1:0] head;
    logic [SEL_W-1:0] head_sel;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;

    assign sel_ok = ({1'b0, s_i} < NUM_C);
    assign drop   = valid_i & ready_o & ~sel_ok;

    stream_fifo2 #(
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .arst_i    (arst_i),
        .in_data   ({s_i, data_i}),
        .in_valid  (valid_i & sel_ok),
        .in_ready  (ready_o),
        .out_data  (head),
        .out_valid (head_valid),
        .out_ready (head_ready)
    );

    assign head_sel = head[WIDTH-1:DATA_W];
    assign data_o   = head[DATA_W-1:0];

    always_comb begin
        valid_o = '0;
        for (int k = 0; k < NUM_ELEM; k++) begin
            valid_o[k] = head_valid && (head_sel == SEL_W'(k));
        end
    end

    // Only the addressed consumer's ready can pop the head.
    assign head_ready = |(valid_o & ready_i);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            err_q <= drop;
            if (drop && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign err_o      = err_q;
    assign drop_cnt_o = cnt_q;

endmodule
